reg_file_clr: RTL and testbench



---
 rtl/reg_file_clr.sv | 113 +++++++++++
 tb/tb_reg_file_clr.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_clr.sv
// Parametrised register file with two combinational read ports, one write port and a sequential bulk-clear engine.
// Optional same-cycle write-to-read forwarding is enabled by defining REG_FILE_BYPASS_EN.
module reg_file_clr #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    input  logic              we,
    input  logic [ADDR_W-1:0] rw,
    input  logic [DATA_W-1:0] din,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              wr_drop,
    output logic [DATA_W-1:0] douta,
    output logic [DATA_W-1:0] doutb
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_wr_zero;
    logic              w_wr_en;

    // Writes aimed at a hardwired-zero entry 0 are neither performed nor reported as dropped.
    assign w_wr_zero = (ZERO_REG != 0) && (rw == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        clr_busy     = 1'b0;
        clr_done     = 1'b0;
        wr_drop      = 1'b0;
        w_wr_en      = 1'b0;
        case (r_state)
            IDLE: begin
                w_wr_en = we && !w_wr_zero;
                if (clr_req) begin
                    w_next_state = CLEAR;
                end
            end
            CLEAR: begin
                clr_busy = 1'b1;
                wr_drop  = we && !w_wr_zero;
                if (r_cnt == '1) begin
                    clr_done     = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (r_state == CLEAR) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    // A write on the IDLE->CLEAR edge still lands; the clear sweep overwrites it later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem <= '{default: '0};
        end else if (r_state == CLEAR) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wr_en) begin
            r_mem[rw] <= din;
        end
    end

    always_comb begin
        douta = r_mem[ra];
        doutb = r_mem[rb];
`ifdef REG_FILE_BYPASS_EN
        if (w_wr_en && (rw == ra)) begin
            douta = din;
        end
        if (w_wr_en && (rw == rb)) begin
            doutb = din;
        end
`endif
        if ((ZERO_REG != 0) && (ra == '0)) begin
            douta = '0;
        end
        if ((ZERO_REG != 0) && (rb == '0)) begin
            doutb = '0;
        end
    end

endmodule

// File: tb/tb_reg_file_clr.sv
// Self-checking bench for reg_file_clr: two instances (ZERO_REG=1 and ZERO_REG=0) driven in lockstep
// against an array-based reference model, plus constant-vector tables and clear-engine sequences.
module tb_reg_file_clr;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic        clr_req;
    logic [4:0]  ra, rb, rw;
    logic [31:0] din;
    logic [31:0] a1, b1, a0, b0;
    logic        busy1, done1, drop1, busy0, done0, drop0;

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl [2][32];
    bit          m_busy;
    int          m_pos;

    always #5 clk = ~clk;

    reg_file_clr #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut1 (
        .clk(clk), .reset(reset), .ra(ra), .rb(rb), .we(we), .rw(rw), .din(din),
        .clr_req(clr_req), .clr_busy(busy1), .clr_done(done1), .wr_drop(drop1),
        .douta(a1), .doutb(b1)
    );

    reg_file_clr #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) dut0 (
        .clk(clk), .reset(reset), .ra(ra), .rb(rb), .we(we), .rw(rw), .din(din),
        .clr_req(clr_req), .clr_busy(busy0), .clr_done(done0), .wr_drop(drop0),
        .douta(a0), .doutb(b0)
    );

    typedef struct {
        logic        we;
        logic [4:0]  rw;
        logic [31:0] din;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] ea1;
        logic [31:0] eb1;
        logic [31:0] ea0;
        logic [31:0] eb0;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int z = 0; z < 2; z++)
            for (int i = 0; i < 32; i++)
                mdl[z][i] = '0;
        m_busy = 1'b0;
        m_pos  = 0;
    endtask

    function automatic logic [31:0] exp_rd(input int zr, input logic [4:0] a);
        if (zr == 1 && a == 5'd0) return '0;
`ifdef REG_FILE_BYPASS_EN
        if (!m_busy && we && !(zr == 1 && rw == 5'd0) && rw == a) return din;
`endif
        return mdl[zr][a];
    endfunction

    function automatic logic exp_drop(input int zr);
        return m_busy && we && !(zr == 1 && rw == 5'd0);
    endfunction

    task automatic check_model();
        logic exp_done;
        exp_done = m_busy && (m_pos == 31);
        chk("m_douta_z1", a1, exp_rd(1, ra));
        chk("m_doutb_z1", b1, exp_rd(1, rb));
        chk("m_douta_z0", a0, exp_rd(0, ra));
        chk("m_doutb_z0", b0, exp_rd(0, rb));
        chk("m_busy_z1", 32'(busy1), 32'(m_busy));
        chk("m_busy_z0", 32'(busy0), 32'(m_busy));
        chk("m_done_z1", 32'(done1), 32'(exp_done));
        chk("m_done_z0", 32'(done0), 32'(exp_done));
        chk("m_drop_z1", 32'(drop1), 32'(exp_drop(1)));
        chk("m_drop_z0", 32'(drop0), 32'(exp_drop(0)));
    endtask

    // Apply the spec's edge rules to the model: write in idle (before clear), one zeroed entry per clear cycle.
    task automatic model_edge();
        if (!reset) begin
            model_reset();
            return;
        end
        if (!m_busy) begin
            for (int z = 0; z < 2; z++)
                if (we && !(z == 1 && rw == 5'd0)) mdl[z][rw] = din;
            if (clr_req) begin
                m_busy = 1'b1;
                m_pos  = 0;
            end
        end else begin
            for (int z = 0; z < 2; z++) mdl[z][m_pos] = '0;
            if (m_pos == 31) begin
                m_busy = 1'b0;
                m_pos  = 0;
            end else begin
                m_pos++;
            end
        end
    endtask

    task automatic tick();
        #1;
        check_model();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic run_clear(output int n_busy, output int n_done, output int done_at);
        n_busy  = 0;
        n_done  = 0;
        done_at = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy1) break;
            n_busy++;
            if (done1) begin
                n_done++;
                done_at = n_busy;
            end
            tick();
        end
    endtask

    initial begin
        int nb, nd, da;

        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd3,  5'd31, 32'h0,        32'h0,        32'h0,        32'h0};
        vecs[1] = '{1'b1, 5'd0,  32'h12345678, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF};
        vecs[3] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd0,  5'd1,  32'h0,        32'h0,        32'h12345678, 32'h0};
        vecs[4] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd31, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D};
        vecs[5] = '{1'b1, 5'd5,  32'h1,        5'd31, 5'd0,  32'hCAFEF00D, 32'h0,        32'hCAFEF00D, 32'h12345678};
        vecs[6] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd31, 32'h1,        32'hCAFEF00D, 32'h1,        32'hCAFEF00D};

        reset = 1'b0; we = 1'b0; clr_req = 1'b0;
        ra = 5'd3; rb = 5'd31; rw = 5'd0; din = '0;
        model_reset();
        #12;
        chk("rst_douta", a1, 32'h0);
        chk("rst_doutb", b1, 32'h0);
        chk("rst_busy", 32'(busy1), 32'h0);
        chk("rst_done", 32'(done1), 32'h0);
        chk("rst_drop", 32'(drop1), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        for (int i = 0; i < 7; i++) begin
            we = vecs[i].we; rw = vecs[i].rw; din = vecs[i].din;
            ra = vecs[i].ra; rb = vecs[i].rb;
            #1;
            chk("vec_douta_z1", a1, vecs[i].ea1);
            chk("vec_doutb_z1", b1, vecs[i].eb1);
            chk("vec_douta_z0", a0, vecs[i].ea0);
            chk("vec_doutb_z0", b0, vecs[i].eb0);
            tick();
        end
        we = 1'b0;

        // Same-cycle write/read of entry 4: old value without forwarding, new value with it.
        we = 1'b1; rw = 5'd4; din = 32'h11;
        tick();
        din = 32'h22; ra = 5'd4; rb = 5'd4;
        #1;
`ifdef REG_FILE_BYPASS_EN
        chk("byp_douta", a1, 32'h22);
        chk("byp_doutb", b1, 32'h22);
`else
        chk("byp_douta", a1, 32'h11);
        chk("byp_doutb", b1, 32'h11);
`endif
        tick();
        we = 1'b0;
        #1;
        chk("byp_next", a1, 32'h22);

        for (int i = 0; i < 32; i++) begin
            we = 1'b1; rw = 5'(i); din = 32'(i + 1);
            tick();
        end
        we = 1'b0; ra = 5'd9; rb = 5'd20;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        nb = 0; nd = 0; da = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy1) break;
            nb++;
            if (done1) begin
                nd++;
                da = nb;
            end
            if (nb == 2) begin
                we = 1'b1; rw = 5'd7; din = 32'hAAAA5555;
                #1;
                chk("drop_cyc2_z1", 32'(drop1), 32'h1);
                chk("drop_cyc2_z0", 32'(drop0), 32'h1);
            end
            if (nb == 11) begin
                #1;
                chk("clr_mem9", a1, 32'h0);
                chk("clr_mem20", b1, 32'd21);
            end
            tick();
            we = 1'b0;
        end
        chk("clr_busy_cycles", 32'(nb), 32'd32);
        chk("clr_done_count", 32'(nd), 32'd1);
        chk("clr_done_cycle", 32'(da), 32'd32);
        for (int i = 0; i < 32; i++) begin
            ra = 5'(i); rb = 5'(31 - i);
            #1;
            chk("post_clr_z0", a0, 32'h0);
            tick();
        end

        we = 1'b1; rw = 5'd31; din = 32'h1; ra = 5'd31; clr_req = 1'b1;
        tick();
        we = 1'b0; clr_req = 1'b0;
        #1;
        chk("wr_before_clr", a1, 32'h1);
        run_clear(nb, nd, da);
        chk("wrclr_cycles", 32'(nb), 32'd32);
        #1;
        chk("wrclr_mem31", a1, 32'h0);

        clr_req = 1'b1;
        tick();
        run_clear(nb, nd, da);
        chk("b2b_first", 32'(nb), 32'd32);
        #1;
        chk("b2b_gap_idle", 32'(busy1), 32'h0);
        tick();
        clr_req = 1'b0;
        run_clear(nb, nd, da);
        chk("b2b_second", 32'(nb), 32'd32);
        chk("b2b_done", 32'(nd), 32'd1);

        for (int i = 1; i < 9; i++) begin
            we = 1'b1; rw = 5'(i * 3); din = $urandom;
            tick();
        end
        we = 1'b0; clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int c = 1; c < 16; c++) tick();
        #1;
        chk("mid_busy_before", 32'(busy1), 32'h1);
        reset = 1'b0;
        #1;
        model_reset();
        chk("mid_busy_z1", 32'(busy1), 32'h0);
        chk("mid_busy_z0", 32'(busy0), 32'h0);
        chk("mid_done", 32'(done1), 32'h0);
        for (int i = 0; i < 32; i++) begin
            ra = 5'(i); rb = 5'(31 - i);
            #1;
            chk("mid_rd_a0", a0, 32'h0);
            chk("mid_rd_b0", b0, 32'h0);
            chk("mid_rd_done", 32'(done0), 32'h0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        run_clear(nb, nd, da);
        chk("restart_cycles", 32'(nb), 32'd32);
        chk("restart_done_at", 32'(da), 32'd32);

        for (int i = 0; i < 400; i++) begin
            we      = 1'($urandom_range(0, 1));
            rw      = 5'($urandom);
            din     = $urandom;
            ra      = 5'($urandom);
            rb      = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom);
            clr_req = ($urandom_range(0, 15) == 0);
            tick();
        end
        we = 1'b0; clr_req = 1'b0;
        run_clear(nb, nd, da);
        #1;
        chk("final_idle", 32'(busy1), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
